vga_timing_gen: RTL and testbench

//  Parametrised VGA timing generator; successor to the fixed vga_640x480 counter block.

---
 rtl/vga_timing_pkg.sv | 30 +++
 rtl/vga_axis_cnt.sv | 57 +++++
 rtl/vga_timing_gen.sv | 126 ++++++++++++
 tb/tb_vga_timing_gen.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared mode constants and helpers for the VGA timing generator family.
package vga_timing_pkg;

  // 640x480 @ 60 Hz (25.175 MHz pixel clock)
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;

  // 800x600 @ 60 Hz (40 MHz pixel clock)
  localparam int SVGA800_H_ACTIVE = 800;
  localparam int SVGA800_H_FP     = 40;
  localparam int SVGA800_H_SYNC   = 128;
  localparam int SVGA800_H_BP     = 88;
  localparam int SVGA800_V_ACTIVE = 600;
  localparam int SVGA800_V_FP     = 1;
  localparam int SVGA800_V_SYNC   = 4;
  localparam int SVGA800_V_BP     = 23;

  // Length of one full line or frame: active area, then FP, SYNC, BP.
  function automatic int axis_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// One timing axis (horizontal or vertical): a wrapping position counter
// plus combinational decode of the active region and the sync pulse.
// Region order along the axis: active, front porch, sync, back porch.
// Decode outputs are derived only from the registered count.
module vga_axis_cnt
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter bit POL    = 1'b0,
  parameter int W      = 10
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         ce,
  output logic [W-1:0] count,
  output logic         wrap,
  output logic         active,
  output logic         sync
);

  localparam int             TOTAL    = axis_total(ACTIVE, FP, SYNC, BP);
  localparam logic [W-1:0]   LAST     = W'(TOTAL - 1);
  localparam logic [W:0]     ACT_END  = (W+1)'(ACTIVE);
  localparam logic [W:0]     SYNC_LO  = (W+1)'(ACTIVE + FP);
  localparam logic [W:0]     SYNC_LEN = (W+1)'(SYNC);

  logic in_sync;

  // Position counter: advances on enabled clocks, wraps at the axis end.
  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (ce) begin
      if (wrap) count <= '0;
      else      count <= count + 1'b1;
    end
  end

  assign wrap   = (count == LAST);
  assign active = ({1'b0, count} < ACT_END);

  // The sync window test uses an offset compare: positions below the window
  // underflow to a value of at least 2**W, which is never below SYNC_LEN.
  if (SYNC == 0) begin : g_no_sync
    assign in_sync = 1'b0;
  end else begin : g_sync
    logic [W:0] sync_off;
    assign sync_off = {1'b0, count} - SYNC_LO;
    assign in_sync  = (sync_off < SYNC_LEN);
  end

  assign sync = in_sync ? POL : ~POL;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator. Stage 1 is a pair of axis counters;
// stage 2 registers every output from the stage 1 decode so that hc/vc,
// syncs, vidon and the line/frame pulses all describe the same pixel and
// no input reaches an output combinationally.
// Enable semantics: pix_ce qualifies every state change except reset and
// the pulse outputs, which are forced low on any clk without pix_ce so they
// stay one clk wide at any pix_ce rate.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA640_H_ACTIVE,
  parameter int H_FP     = VGA640_H_FP,
  parameter int H_SYNC   = VGA640_H_SYNC,
  parameter int H_BP     = VGA640_H_BP,
  parameter int V_ACTIVE = VGA640_V_ACTIVE,
  parameter int V_FP     = VGA640_V_FP,
  parameter int V_SYNC   = VGA640_V_SYNC,
  parameter int V_BP     = VGA640_V_BP,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int CNT_W    = 10
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             pix_ce,
  output logic             hsync,
  output logic             vsync,
  output logic             vidon,
  output logic [CNT_W-1:0] hc,
  output logic [CNT_W-1:0] vc,
  output logic             line_start,
  output logic             frame_start,
  output logic [7:0]       frame_cnt
);

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             h_wrap, v_wrap;
  logic             h_act, v_act;
  logic             h_sync, v_sync;
  logic             v_ce;
  logic             line_top;   // stage 1 sits at h_cnt == 0
  logic             frame_top;  // stage 1 sits at h_cnt == 0 && v_cnt == 0
  logic             cnt_armed;  // first frame after reset is not counted

  assign v_ce = pix_ce & h_wrap;

  vga_axis_cnt #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (H_POL),
    .W      (CNT_W)
  ) h (
    .clk    (clk),
    .clr    (clr),
    .ce     (pix_ce),
    .count  (h_cnt),
    .wrap   (h_wrap),
    .active (h_act),
    .sync   (h_sync)
  );

  vga_axis_cnt #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (V_POL),
    .W      (CNT_W)
  ) v (
    .clk    (clk),
    .clr    (clr),
    .ce     (v_ce),
    .count  (v_cnt),
    .wrap   (v_wrap),
    .active (v_act),
    .sync   (v_sync)
  );

  // Track when stage 1 is at the start of a line / frame, mirroring the wraps.
  always_ff @(posedge clk) begin
    if (clr) begin
      line_top  <= 1'b1;
      frame_top <= 1'b1;
    end else if (pix_ce) begin
      line_top  <= h_wrap;
      frame_top <= h_wrap & v_wrap;
    end
  end

  // Stage 2: present the stage 1 pixel; pulses last only one clk.
  always_ff @(posedge clk) begin
    if (clr) begin
      hc          <= '0;
      vc          <= '0;
      vidon       <= 1'b0;
      hsync       <= ~H_POL;
      vsync       <= ~V_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= pix_ce & line_top;
      frame_start <= pix_ce & frame_top;
      if (pix_ce) begin
        hc    <= h_cnt;
        vc    <= v_cnt;
        vidon <= h_act & v_act;
        hsync <= h_sync;
        vsync <= v_sync;
      end
    end
  end

  // Completed-frame counter, stepping in step with frame_start.
  always_ff @(posedge clk) begin
    if (clr) begin
      frame_cnt <= 8'd0;
      cnt_armed <= 1'b0;
    end else if (pix_ce && frame_top) begin
      if (cnt_armed) frame_cnt <= frame_cnt + 8'd1;
      cnt_armed <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen using reduced modes so whole frames run quickly.
// Instance a: active-low syncs, all regions present (15 x 8 totals).
// Instance b: active-high syncs with zero-length porches (9 x 5 totals).
module tb_vga_timing_gen;

  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;  // 15
  localparam int VT = VA + VF + VS + VB;  // 8
  localparam int W  = 4;
  localparam int VW = 2 * W + 13;         // {hc,vc,hsync,vsync,vidon,ls,fs,frame_cnt}

  localparam int BHA = 6, BHF = 0, BHS = 2, BHB = 1;  // H total 9
  localparam int BVA = 3, BVF = 1, BVS = 1, BVB = 0;  // V total 5

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic clr = 1'b1;
  logic pix_ce = 1'b0;
  always #5 clk = ~clk;

  logic         hsync, vsync, vidon, line_start, frame_start;
  logic [W-1:0] hc, vc;
  logic [7:0]   frame_cnt;
  logic         b_hsync, b_vsync, b_vidon, b_line_start, b_frame_start;
  logic [W-1:0] b_hc, b_vc;
  logic [7:0]   b_frame_cnt;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(1'b0), .V_POL(1'b0), .CNT_W(W)
  ) dut (
    .clk(clk), .clr(clr), .pix_ce(pix_ce),
    .hsync(hsync), .vsync(vsync), .vidon(vidon), .hc(hc), .vc(vc),
    .line_start(line_start), .frame_start(frame_start), .frame_cnt(frame_cnt)
  );

  vga_timing_gen #(
    .H_ACTIVE(BHA), .H_FP(BHF), .H_SYNC(BHS), .H_BP(BHB),
    .V_ACTIVE(BVA), .V_FP(BVF), .V_SYNC(BVS), .V_BP(BVB),
    .H_POL(1'b1), .V_POL(1'b1), .CNT_W(W)
  ) dut_b (
    .clk(clk), .clr(clr), .pix_ce(pix_ce),
    .hsync(b_hsync), .vsync(b_vsync), .vidon(b_vidon), .hc(b_hc), .vc(b_vc),
    .line_start(b_line_start), .frame_start(b_frame_start), .frame_cnt(b_frame_cnt)
  );

  // ---------------- scoreboard state ----------------
  logic [VW-1:0] exp_q[$];
  logic [VW-1:0] last_exp;
  logic [VW-1:0] e;
  int            mh, mv;
  logic [7:0]    mfc;
  bit            mskip;
  int            checks = 0;
  int            passed = 0;

  function automatic logic [VW-1:0] got_vec();
    return {hc, vc, hsync, vsync, vidon, line_start, frame_start, frame_cnt};
  endfunction

  // ---------------- driver ----------------
  // Drives one clk of clr/pix_ce, pushes the expected presented state, and
  // returns #1 after the active edge so outputs can be sampled.
  task automatic step(input bit rst, input bit ce);
    logic [VW-1:0] x;
    logic ehs, evs, eva, els, efs;
    @(negedge clk);
    clr    = rst;
    pix_ce = ce;
    if (rst) begin
      mh = 0; mv = 0; mfc = 8'd0; mskip = 1'b1;
      x = {{W{1'b0}}, {W{1'b0}}, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    end else begin
      x = last_exp;
      x[9:8] = 2'b00;
      if (ce) begin
        ehs = (mh >= HA + HF && mh < HA + HF + HS) ? 1'b0 : 1'b1;
        evs = (mv >= VA + VF && mv < VA + VF + VS) ? 1'b0 : 1'b1;
        eva = (mh < HA) && (mv < VA);
        els = (mh == 0);
        efs = (mh == 0) && (mv == 0);
        if (efs) begin
          if (mskip) mskip = 1'b0;
          else       mfc = mfc + 8'd1;
        end
        x = {W'(mh), W'(mv), ehs, evs, eva, els, efs, mfc};
        mh++;
        if (mh == HT) begin
          mh = 0;
          mv++;
          if (mv == VT) mv = 0;
        end
      end
    end
    last_exp = x;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      step(i < 3, 1'b1 & (i < 3));  // clr with pix_ce high, then idle clks
      e = exp_q.pop_front();
      checks++;
      if (got_vec() !== e) $display("FAIL reset[%0d] got=%h exp=%h", i, got_vec(), e);
      else passed++;
    end
  endtask

  task automatic test_full_rate();
    int hs_cnt = 0, hs_first = -1, lines = 0;
    int vs_cnt = 0, vs_first = -1, vid_cnt = 0, frames = 0, fs_gap = 0;
    for (int i = 0; i < 2 * HT * VT + 1; i++) begin
      step(1'b0, 1'b1);
      e = exp_q.pop_front();
      checks++;
      if (got_vec() !== e) $display("FAIL full_rate[%0d] got=%h exp=%h", i, got_vec(), e);
      else passed++;
      if (line_start) begin
        if (lines > 0) begin
          checks++;
          if (hs_cnt !== HS || hs_first !== HA + HF)
            $display("FAIL hsync_window got=%0d@%0d exp=%0d@%0d", hs_cnt, hs_first, HS, HA + HF);
          else passed++;
        end
        lines++; hs_cnt = 0; hs_first = -1;
      end
      if (frame_start) begin
        if (frames > 0) begin
          checks++;
          if (fs_gap !== HT * VT || vid_cnt !== HA * VA || vs_cnt !== VS * HT || vs_first !== VA + VF)
            $display("FAIL frame_shape got=gap%0d vid%0d vs%0d@%0d exp=gap%0d vid%0d vs%0d@%0d",
                     fs_gap, vid_cnt, vs_cnt, vs_first, HT * VT, HA * VA, VS * HT, VA + VF);
          else passed++;
        end
        frames++; fs_gap = 0; vid_cnt = 0; vs_cnt = 0; vs_first = -1;
      end
      fs_gap++;
      if (hsync == 1'b0) begin hs_cnt++; if (hs_first < 0) hs_first = int'(hc); end
      if (vsync == 1'b0) begin vs_cnt++; if (vs_first < 0) vs_first = int'(vc); end
      if (vidon) begin
        vid_cnt++;
        checks++;
        if (int'(hc) >= HA || int'(vc) >= VA)
          $display("FAIL vidon_blank got=1 exp=0 hc=%0d vc=%0d", hc, vc);
        else passed++;
      end
    end
  endtask

  task automatic test_sparse_ce();
    for (int i = 0; i < 4 * HT * VT + 8; i++) begin
      step(1'b0, (i % 4) == 3);
      e = exp_q.pop_front();
      checks++;
      if (got_vec() !== e) $display("FAIL sparse_ce[%0d] got=%h exp=%h", i, got_vec(), e);
      else passed++;
    end
  endtask

  task automatic test_random_ce();
    for (int i = 0; i < 600; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)));
      e = exp_q.pop_front();
      checks++;
      if (got_vec() !== e) $display("FAIL random_ce[%0d] got=%h exp=%h", i, got_vec(), e);
      else passed++;
    end
  endtask

  task automatic test_mid_reset();
    int budget = 2 * HT * VT;
    while (!(last_exp[VW-1 -: W] == W'(5) && last_exp[VW-W-1 -: W] == W'(2)) && budget > 0) begin
      step(1'b0, 1'b1);
      e = exp_q.pop_front();
      checks++;
      if (got_vec() !== e) $display("FAIL mid_run got=%h exp=%h", got_vec(), e);
      else passed++;
      budget--;
    end
    checks++;
    if (budget == 0) $display("FAIL mid_reset_reach got=timeout exp=hc5_vc2");
    else passed++;
    step(1'b1, 1'b1);
    e = exp_q.pop_front();
    checks++;
    if (got_vec() !== e) $display("FAIL mid_reset got=%h exp=%h", got_vec(), e);
    else passed++;
    step(1'b0, 1'b1);
    e = exp_q.pop_front();
    checks++;
    if (got_vec() !== e) $display("FAIL post_reset_first got=%h exp=%h", got_vec(), e);
    else passed++;
    checks++;
    if (frame_start !== 1'b1 || line_start !== 1'b1 || vidon !== 1'b1 || frame_cnt !== 8'd0)
      $display("FAIL post_reset_pulse got=fs%b ls%b vid%b cnt%0d exp=fs1 ls1 vid1 cnt0",
               frame_start, line_start, vidon, frame_cnt);
    else passed++;
  endtask

  task automatic test_frame_wrap();
    int fs_seen = 0;
    int budget = 258 * HT * VT;
    step(1'b1, 1'b0);
    e = exp_q.pop_front();
    checks++;
    if (got_vec() !== e) $display("FAIL wrap_reset got=%h exp=%h", got_vec(), e);
    else passed++;
    while (fs_seen < 257 && budget > 0) begin
      step(1'b0, 1'b1);
      e = exp_q.pop_front();
      checks++;
      if (got_vec() !== e) $display("FAIL frame_wrap got=%h exp=%h", got_vec(), e);
      else passed++;
      if (e[8]) begin
        fs_seen++;
        if (fs_seen == 256) begin
          checks++;
          if (frame_cnt !== 8'd255) $display("FAIL frame_cnt_255 got=%0d exp=255", frame_cnt);
          else passed++;
        end
        if (fs_seen == 257) begin
          checks++;
          if (frame_cnt !== 8'd0) $display("FAIL frame_cnt_wrap got=%0d exp=0", frame_cnt);
          else passed++;
        end
      end
      budget--;
    end
    checks++;
    if (fs_seen != 257) $display("FAIL frame_wrap_budget got=%0d exp=257", fs_seen);
    else passed++;
  endtask

  task automatic test_zero_porch();
    int hs_cnt = 0, hs_first = -1, lines = 0, line_len = 0;
    int vs_cnt = 0, vs_first = -1, vid_cnt = 0, frames = 0, fs_gap = 0;
    localparam int BHT = BHA + BHF + BHS + BHB;
    localparam int BVT = BVA + BVF + BVS + BVB;
    step(1'b1, 1'b0);
    e = exp_q.pop_front();
    checks++;
    if (b_hsync !== 1'b0 || b_vsync !== 1'b0 || b_vidon !== 1'b0 || got_vec() !== e)
      $display("FAIL zp_reset got=hs%b vs%b vid%b a=%h exp=hs0 vs0 vid0 a=%h",
               b_hsync, b_vsync, b_vidon, got_vec(), e);
    else passed++;
    for (int i = 0; i < 2 * BHT * BVT + 1; i++) begin
      step(1'b0, 1'b1);
      e = exp_q.pop_front();
      checks++;
      if (got_vec() !== e) $display("FAIL zp_main got=%h exp=%h", got_vec(), e);
      else passed++;
      if (b_line_start) begin
        if (lines > 0) begin
          checks++;
          if (hs_cnt !== BHS || hs_first !== BHA + BHF || line_len !== BHT)
            $display("FAIL zp_line got=hs%0d@%0d len%0d exp=hs%0d@%0d len%0d",
                     hs_cnt, hs_first, line_len, BHS, BHA + BHF, BHT);
          else passed++;
        end
        lines++; hs_cnt = 0; hs_first = -1; line_len = 0;
      end
      if (b_frame_start) begin
        if (frames > 0) begin
          checks++;
          if (fs_gap !== BHT * BVT || vid_cnt !== BHA * BVA || vs_cnt !== BVS * BHT || vs_first !== BVA + BVF)
            $display("FAIL zp_frame got=gap%0d vid%0d vs%0d@%0d exp=gap%0d vid%0d vs%0d@%0d",
                     fs_gap, vid_cnt, vs_cnt, vs_first, BHT * BVT, BHA * BVA, BVS * BHT, BVA + BVF);
          else passed++;
        end
        frames++; fs_gap = 0; vid_cnt = 0; vs_cnt = 0; vs_first = -1;
      end
      line_len++;
      fs_gap++;
      if (b_hsync == 1'b1) begin hs_cnt++; if (hs_first < 0) hs_first = int'(b_hc); end
      if (b_vsync == 1'b1) begin vs_cnt++; if (vs_first < 0) vs_first = int'(b_vc); end
      if (b_vidon) vid_cnt++;
    end
    checks++;
    if (b_frame_cnt !== 8'd2) $display("FAIL zp_frame_cnt got=%0d exp=2", b_frame_cnt);
    else passed++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    last_exp = '0;
    mh = 0; mv = 0; mfc = 8'd0; mskip = 1'b1;
    test_reset();
    test_full_rate();
    test_sparse_ce();
    test_random_ce();
    test_mid_reset();
    test_frame_wrap();
    test_zero_porch();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
